// File: rtl/pipelined_cla_adder_pkg.sv
// pipelined_cla_adder shared package
// op encodings, default segment width, carry-in helper
package pipelined_cla_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADDC = 2'b10;
  localparam logic [1:0] OP_SUBB = 2'b11;

  localparam int SEG_W_DEF = 4;

  // SUBB inverts the borrow so cin=1 takes one more away
  function automatic logic eff_c0(
    input logic [1:0] op,
    input logic       cin
  );
    logic c;
    unique case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      OP_ADDC: c = cin;
      OP_SUBB: c = ~cin;
    endcase
    return c;
  endfunction

  function automatic logic is_sub(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SUBB);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// pipelined_cla_adder operand/result bus
// master drives operands and consumes results
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/pipelined_cla_adder_segment.sv
// cla_segment: combinational SEG_W-bit lookahead slice
// carries are flat sum-of-products, no ripple chain
module cla_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b_eff,
  input  logic             c_in,
  output logic [SEG_W-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [SEG_W-1:0] p;
  logic [SEG_W-1:0] g;
  logic [SEG_W:0]   c;
  logic             t;
  logic             pp;

  assign p = a ^ b_eff;
  assign g = a & b_eff;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in
  always_comb begin
    c    = '0;
    t    = 1'b0;
    pp   = 1'b0;
    c[0] = c_in;
    for (int i = 0; i < SEG_W; i++) begin
      t  = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t  = t | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = t | (pp & c_in);
    end
  end

  assign s        = p ^ c[SEG_W-1:0];
  assign c_out    = c[SEG_W];
  assign c_msb_in = c[SEG_W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: one lookahead segment per stage
// skew/de-skew ranks, registered carries, global stall
module pipelined_cla_adder
  import pipelined_cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = SEG_W_DEF
) (
  input logic clk,
  input logic rst_n,
  pipelined_cla_adder_if.slave bus
);

  localparam int NSEG = WIDTH / SEG_W;

  logic adv;

  // rank k feeds segment k
  logic             rv [NSEG];
  logic [WIDTH-1:0] ra [NSEG];
  logic [WIDTH-1:0] rb [NSEG];
  logic             rc [NSEG];
  logic [WIDTH-1:0] rs [NSEG];

  logic [SEG_W-1:0] seg_s  [NSEG];
  logic             seg_co [NSEG];
  logic             seg_cm [NSEG];
  logic [WIDTH-1:0] s_nxt  [NSEG];

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam logic [WIDTH-1:0] MSK =
      {{(WIDTH-SEG_W){1'b0}}, {SEG_W{1'b1}}} << (k * SEG_W);

    cla_segment #(
      .SEG_W(SEG_W)
    ) u_seg (
      .a       (ra[k][k*SEG_W +: SEG_W]),
      .b_eff   (rb[k][k*SEG_W +: SEG_W]),
      .c_in    (rc[k]),
      .s       (seg_s[k]),
      .c_out   (seg_co[k]),
      .c_msb_in(seg_cm[k])
    );

    assign s_nxt[k] = (rs[k] & ~MSK)
                    | ({{(WIDTH-SEG_W){1'b0}}, seg_s[k]}
                       << (k * SEG_W));
  end

  // shift every rank by one on advance, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        rv[k] <= 1'b0;
        ra[k] <= '0;
        rb[k] <= '0;
        rc[k] <= 1'b0;
        rs[k] <= '0;
      end
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.zero      <= 1'b0;
    end else if (adv) begin
      rv[0] <= bus.in_valid;
      ra[0] <= bus.a;
      rb[0] <= is_sub(bus.op) ? ~bus.b : bus.b;
      rc[0] <= eff_c0(bus.op, bus.cin);
      rs[0] <= '0;
      for (int k = 1; k < NSEG; k++) begin
        rv[k] <= rv[k-1];
        ra[k] <= ra[k-1];
        rb[k] <= rb[k-1];
        rc[k] <= seg_co[k-1];
        rs[k] <= s_nxt[k-1];
      end
      bus.out_valid <= rv[NSEG-1];
      if (rv[NSEG-1]) begin
        bus.sum  <= s_nxt[NSEG-1];
        bus.cout <= seg_co[NSEG-1];
        bus.ovf  <= seg_co[NSEG-1] ^ seg_cm[NSEG-1];
        bus.zero <= (s_nxt[NSEG-1] == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench
// WIDTH=16, SEG_W=4, latency 4
module tb_pipelined_cla_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   ecnt     = 0;
  exp_t q[$];

  bit          hold_pend = 1'b0;
  logic [15:0] h_sum;
  logic        h_cout;
  logic        h_ovf;
  logic        h_zero;

  pipelined_cla_adder_if #(.WIDTH(16)) bus();

  pipelined_cla_adder #(
    .WIDTH(16),
    .SEG_W(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // edge counter for latency measurement
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [1:0]  op,
    input logic        cin
  );
    exp_t        m;
    logic [15:0] be;
    logic        c0;
    logic [16:0] r;
    be = op[0] ? ~b : b;
    case (op)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = 1'b1;
      2'b10:   c0 = cin;
      default: c0 = ~cin;
    endcase
    r      = {1'b0, a} + {1'b0, be} + {16'd0, c0};
    m.sum  = r[15:0];
    m.cout = r[16];
    m.ovf  = (a[15] == be[15]) && (r[15] != a[15]);
    m.zero = (r[15:0] == 16'd0);
    m.acc  = 0;
    m.lat  = 1'b0;
    return m;
  endfunction

  function automatic exp_t mk(
    input logic [15:0] s,
    input logic        c,
    input logic        o,
    input logic        z
  );
    exp_t m;
    m.sum  = s;
    m.cout = c;
    m.ovf  = o;
    m.zero = z;
    m.acc  = 0;
    m.lat  = 1'b1;
    return m;
  endfunction

  // retire results against the scoreboard, check holds under stall
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      hold_pend <= 1'b0;
    end else if (bus.out_valid) begin
      if (hold_pend) begin
        chk("hold_sum", bus.sum, h_sum);
        chk("hold_cout", bus.cout, h_cout);
        chk("hold_ovf", bus.ovf, h_ovf);
        chk("hold_zero", bus.zero, h_zero);
      end
      if (bus.out_ready) begin
        hold_pend <= 1'b0;
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sum", bus.sum, e.sum);
          chk("cout", bus.cout, e.cout);
          chk("ovf", bus.ovf, e.ovf);
          chk("zero", bus.zero, e.zero);
          if (e.lat) chk("latency", ecnt - e.acc, 4);
        end
      end else begin
        hold_pend <= 1'b1;
        h_sum     <= bus.sum;
        h_cout    <= bus.cout;
        h_ovf     <= bus.ovf;
        h_zero    <= bus.zero;
      end
    end else begin
      hold_pend <= 1'b0;
    end
  end

  task automatic send(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [1:0]  op,
    input logic        cin,
    input exp_t        e
  );
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    bus.cin      = cin;
    for (int n = 0; n < 20 && !done; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      if (bus.in_ready) begin
        e.acc = ecnt + 1;
        q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && q.size() != 0; n++) @(negedge clk);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit          stall;
    bit          need;
    int          i;
    exp_t        e;
    logic [15:0] sa;
    logic [15:0] sb;
    logic [1:0]  sop;
    logic        scin;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 2'b00;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_zero", bus.zero, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1);

    send(16'h24D7, 16'h0712, 2'b00, 1'b0, mk(16'h2BE9, 0, 0, 0));
    send(16'hFDE8, 16'h0712, 2'b00, 1'b0, mk(16'h04FA, 1, 0, 0));
    send(16'h7FFF, 16'h0001, 2'b00, 1'b0, mk(16'h8000, 0, 1, 0));
    send(16'h0005, 16'h0007, 2'b01, 1'b0, mk(16'hFFFE, 0, 0, 0));
    send(16'h1234, 16'h1234, 2'b01, 1'b0, mk(16'h0000, 1, 0, 1));
    send(16'hFFFF, 16'h0000, 2'b10, 1'b1, mk(16'h0000, 1, 0, 1));
    idle();
    drain();

    i    = 0;
    need = 1'b1;
    sa   = '0;
    sb   = '0;
    sop  = '0;
    scin = 1'b0;
    for (int c = 0; c < 40 && i < 8; c++) begin
      if (need) begin
        sa   = 16'($urandom);
        sb   = 16'($urandom);
        sop  = 2'($urandom_range(0, 3));
        scin = 1'($urandom_range(0, 1));
        need = 1'b0;
      end
      @(posedge clk);
      #1;
      stall         = (c >= 5) && (c <= 7);
      bus.out_ready = !stall;
      bus.in_valid  = 1'b1;
      bus.a         = sa;
      bus.b         = sb;
      bus.op        = sop;
      bus.cin       = scin;
      @(negedge clk);
      chk("in_ready_stream", bus.in_ready, !stall);
      if (bus.in_ready) begin
        e     = model(sa, sb, sop, scin);
        e.acc = ecnt + 1;
        q.push_back(e);
        i++;
        need = 1'b1;
      end
    end
    chk("stream_count", i, 8);
    idle();
    bus.out_ready = 1'b1;
    drain();

    for (int k = 0; k < 3; k++) begin
      sa  = 16'($urandom);
      sb  = 16'($urandom);
      sop = 2'($urandom_range(0, 3));
      send(sa, sb, sop, 1'b1, model(sa, sb, sop, 1'b1));
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_sum", bus.sum, 0);
    chk("midrst_cout", bus.cout, 0);
    chk("midrst_ovf", bus.ovf, 0);
    chk("midrst_zero", bus.zero, 0);
    q.delete();
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stale_out_valid", bus.out_valid, 0);
    end
    send(16'h1000, 16'h0001, 2'b11, 1'b1, mk(16'h0FFE, 1, 0, 0));
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead add/subtract unit, the streaming successor to the team's fixed 16-bit ripple and 4-bit-CLA adders. Operands are split into SEG_W-bit segments. Each pipeline stage resolves one segment with a lookahead slice, and the carry is registered between stages. Full throughput is one operation per cycle, with valid/ready handshakes on both sides. It sits between operand-issue logic and any downstream consumer that can apply backpressure.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a positive multiple of SEG_W.
- SEG_W, 4, segment width resolved per pipeline stage.
- NSEG, WIDTH/SEG_W (derived, not overridable), pipeline depth.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00 ADD, 01 SUB, 10 ADDC, 11 SUBB.
- cin  in  1  carry/borrow-in; used only by ADDC/SUBB.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result this cycle.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of MSB.
- ovf  out  1  two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- Effective operands: b_eff = b for ADD/ADDC, ~b for SUB/SUBB.
- Effective carry-in c0: 0 for ADD, 1 for SUB, cin for ADDC, ~cin for SUBB.
  - SUBB with cin=1 therefore subtracts an extra 1.
- Stage k (0..NSEG-1) does the following:
  - Computes sum bits [k*SEG_W +: SEG_W] from the skewed operand copy and the registered carry of stage k-1 (c0 for k=0).
  - Uses per-bit P=a^b, G=a&b and full lookahead within the segment.
  - Passes the segment carry-out to stage k+1.
- Operand bits not yet consumed travel down a skew register alongside the data. Sum bits already produced travel down a de-skew register. This keeps each operation's fields aligned.
- cout is the carry out of the final segment. For SUB it equals 1 when a >= b unsigned, i.e. no borrow.
- ovf = carry into MSB XOR carry out of MSB.
- zero is evaluated on the final assembled sum.
- Arithmetic is modulo 2^WIDTH.
- Each stage holds a valid bit; bubbles propagate as invalid stages.
- Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - When advance is low, every stage register, valid bit and output holds.
  - When advance is high, all stages shift by one.
  - A beat is captured only on in_valid && in_ready.
- No state machine beyond per-stage valid bits. Operations never reorder.

## Timing
- Reset (rst_n low, asynchronous) clears to 0, immediately:
  - all valid bits;
  - out_valid, sum, cout, ovf, zero.
- in_ready is 1 from the first clock after reset release.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NSEG, provided no stall intervenes. For WIDTH=16, SEG_W=4 this is 4 cycles.
- Throughput: 1 beat/cycle while out_ready=1.
- Each stall cycle delays every in-flight beat by exactly one cycle.
- While out_valid && !out_ready, sum/cout/ovf/zero are stable.
- Simultaneous out_ready and in_valid with a full pipe: the output is retired and a new beat is accepted in the same cycle, with no bubble.
- Reset mid-operation: all in-flight beats are discarded and none emerge after release.
- in_ready is combinational from out_valid/out_ready (one gate). in_valid is not used combinationally by any output.

## Structure
- Package pipelined_cla_pkg holds:
  - op encodings OP_ADD, OP_SUB, OP_ADDC, OP_SUBB;
  - default SEG_W;
  - a function computing effective c0 from op/cin.
- Sub-module cla_segment: purely combinational SEG_W-bit lookahead slice.
  - Inputs: a, b_eff, c_in. Outputs: s, c_out, c_msb_in (carry into top bit, used for ovf).
  - Instantiated NSEG times via generate.
- Top level contains only the skew/de-skew registers, carries, valid bits and stall logic.

## Test plan
All scenarios use WIDTH=16, SEG_W=4.
- ADD 0x24D7 + 0x0712 -> sum 0x2BE9, cout 0, ovf 0, zero 0, out_valid exactly 4 cycles after acceptance.
- ADD 0xFDE8 + 0x0712 -> sum 0x04FA, cout 1, ovf 0.
- ADD 0x7FFF + 0x0001 -> 0x8000, ovf 1, cout 0.
- SUB 0x0005 - 0x0007 -> 0xFFFE, cout 0.
- SUB 0x1234 - 0x1234 -> 0x0000, cout 1, zero 1.
- ADDC 0xFFFF + 0x0000 with cin=1 -> 0x0000, cout 1, zero 1.
- Stream of 8 back-to-back random beats; out_ready low for 3 cycles mid-stream:
  - in_ready low for exactly those cycles;
  - outputs held stable;
  - all 8 results correct and in order against a reference model;
  - no beat lost or duplicated.
- Reset mid-operation: assert rst_n low with 3 beats in flight for less than one clock period, then release:
  - out_valid=0 and all outputs 0 immediately on assertion;
  - no stale result ever emerges;
  - the next accepted beat returns the correct result after 4 cycles.
